// File: rtl/filter_pkg.sv
// Shared defaults and FSM state type for the filter coefficient store controller.
package filter_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/filter_rd_pipe.sv
// Delay line that realigns the read-issue tags (valid/idx/last) with the store's
// read data, which returns RD_LAT cycles after the read is issued.
module filter_rd_pipe #(
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] idx,
    input  logic              last,
    output logic              valid_dly,
    output logic [ADDR_W-1:0] idx_dly,
    output logic              last_dly
);

    logic              valid_sr [RD_LAT];
    logic [ADDR_W-1:0] idx_sr   [RD_LAT];
    logic              last_sr  [RD_LAT];

    // Reset clears the whole line so an aborted burst never leaks a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                valid_sr[i] <= 1'b0;
                idx_sr[i]   <= '0;
                last_sr[i]  <= 1'b0;
            end
        end else begin
            valid_sr[0] <= valid;
            idx_sr[0]   <= idx;
            last_sr[0]  <= last;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                idx_sr[i]   <= idx_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign valid_dly = valid_sr[RD_LAT-1];
    assign idx_dly   = idx_sr[RD_LAT-1];
    assign last_dly  = last_sr[RD_LAT-1];

endmodule

// File: rtl/filter_storage_ctrl.sv
// Arbiter/sequencer for the filter coefficient store: host writes when idle,
// engine bursts read N coefficients and stream them out with index/last tags.
module filter_storage_ctrl
    import filter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] coef_base,
    input  logic [ADDR_W:0]   ntaps,
    output logic              busy,
    output logic              coef_valid,
    output logic [DATA_W-1:0] coef_data,
    output logic [ADDR_W-1:0] coef_idx,
    output logic              coef_last,
    output logic              done,
    output logic              start_drop,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_wrptr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_rdptr,
    input  logic [DATA_W-1:0] mem_rddata
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_N    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic              rdy_en;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   n_clamp;
    logic              start_ok;
    logic              issue_last;
    logic              drain_end;

    assign n_clamp    = (ntaps > DEPTH_N) ? DEPTH_N : ntaps;
    assign start_ok   = start && rdy_en && (state == IDLE);
    assign issue_last = ({1'b0, cnt_q} == (n_q - (ADDR_W+1)'(1)));
    assign drain_end  = (cnt_q == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok)   state_nxt = (n_clamp == '0) ? DONE : READ;
            READ:    if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (drain_end)  state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // start wins over a same-cycle host write, so the store never sees both ports active.
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        mem_rden   = (state == READ);
        mem_rdptr  = base_q + cnt_q;
        start_drop = start && (state != IDLE);
        cfg_ready  = rdy_en && (state == IDLE) && !start;
    end

    // cnt_q indexes taps during READ, then times the RD_LAT drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            base_q <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (start_ok) begin
                base_q <= coef_base;
                n_q    <= n_clamp;
                cnt_q  <= '0;
            end else if (state == READ) begin
                cnt_q <= issue_last ? '0 : cnt_q + ADDR_W'(1);
            end else if (state == DRAIN) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wren   <= 1'b0;
            mem_wrptr  <= '0;
            mem_wrdata <= '0;
        end else begin
            mem_wren <= cfg_valid && cfg_ready;
            if (cfg_valid && cfg_ready) begin
                mem_wrptr  <= cfg_addr;
                mem_wrdata <= cfg_data;
            end
        end
    end

    filter_rd_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (mem_rden),
        .idx       (cnt_q),
        .last      (mem_rden && issue_last),
        .valid_dly (coef_valid),
        .idx_dly   (coef_idx),
        .last_dly  (coef_last)
    );

    assign coef_data = mem_rddata;

endmodule

// File: tb/tb_filter_storage_ctrl.sv
// Directed bench for filter_storage_ctrl with a behavioural 512x16 store and a
// scoreboard of expected coefficient beats.
module tb_filter_storage_ctrl;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 512;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              start;
    logic [ADDR_W-1:0] coef_base;
    logic [ADDR_W:0]   ntaps;
    logic              busy;
    logic              coef_valid;
    logic [DATA_W-1:0] coef_data;
    logic [ADDR_W-1:0] coef_idx;
    logic              coef_last;
    logic              done;
    logic              start_drop;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_wrptr;
    logic [DATA_W-1:0] mem_wrdata;
    logic              mem_rden;
    logic [ADDR_W-1:0] mem_rdptr;
    logic [DATA_W-1:0] mem_rddata;

    logic [DATA_W-1:0] mem_model [DEPTH];
    logic [DATA_W-1:0] tb_coef   [DEPTH];
    exp_t              sb [$];
    logic [ADDR_W-1:0] rdptr_log [$];
    int                beats;
    int                n_checks;
    int                n_pass;
    int                n_fail;

    filter_storage_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .coef_base  (coef_base),
        .ntaps      (ntaps),
        .busy       (busy),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_idx   (coef_idx),
        .coef_last  (coef_last),
        .done       (done),
        .start_drop (start_drop),
        .mem_wren   (mem_wren),
        .mem_wrptr  (mem_wrptr),
        .mem_wrdata (mem_wrdata),
        .mem_rden   (mem_rden),
        .mem_rdptr  (mem_rdptr),
        .mem_rddata (mem_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural store with a one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wren) mem_model[mem_wrptr] <= mem_wrdata;
        if (mem_rden) mem_rddata <= mem_model[mem_rdptr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        assert (obs === exp_v) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                                 input logic st, input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] nt);
        @(negedge clk);
        cfg_valid = cv;
        cfg_addr  = ca;
        cfg_data  = cd;
        start     = st;
        coef_base = base;
        ntaps     = nt;
        #1;
    endtask

    // Scoreboard consumer: every beat must match the next expected entry in order.
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (rst_n) begin
            if (mem_rden) rdptr_log.push_back(mem_rdptr);
            if (coef_valid) begin
                beats++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("coef_data", coef_data, e.data);
                    checkOutput("coef_idx", coef_idx, e.idx);
                    checkOutput("coef_last", coef_last, e.last);
                end
            end
        end
    end

    task automatic runBurst(input logic [ADDR_W-1:0] base, input int nt, input int drop_at,
                            input logic cv, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
        int n, done_k, first_k, busy_bad, wr_seen, budget, exp_done;
        n = (nt > DEPTH) ? DEPTH : nt;
        for (int i = 0; i < n; i++)
            sb.push_back('{data: tb_coef[(int'(base) + i) % DEPTH], idx: ADDR_W'(i), last: (i == n - 1)});
        beats = 0;
        rdptr_log.delete();
        applyStimulus(cv, ca, cd, 1'b1, base, (ADDR_W+1)'(nt));
        checkOutput("cfg_ready_on_start", cfg_ready, 0);
        done_k = 0; first_k = 0; busy_bad = 0; wr_seen = 0;
        budget = n + RD_LAT + 8;
        for (int k = 1; k <= budget && done_k == 0; k++) begin
            applyStimulus(cv, ca, cd, (k == drop_at), 9'h1F0, 10'd3);
            if (k == drop_at) checkOutput("start_drop", start_drop, 1);
            if (coef_valid && first_k == 0) first_k = k;
            if (!busy) busy_bad++;
            if (mem_wren || cfg_ready) wr_seen++;
            if (done) done_k = k;
        end
        exp_done = (n == 0) ? 1 : n + RD_LAT + 1;
        checkOutput("done_cycle", done_k, exp_done);
        checkOutput("first_valid_cycle", first_k, (n == 0) ? 0 : RD_LAT + 1);
        checkOutput("busy_held", busy_bad, 0);
        checkOutput("no_write_in_burst", wr_seen, 0);
        applyStimulus(cv, ca, cd, 1'b0, '0, '0);
        checkOutput("busy_after_done", busy, 0);
        #2;
        checkOutput("beat_count", beats, n);
        checkOutput("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        logic [9:0] host_addr;
        n_checks = 0; n_pass = 0; n_fail = 0; beats = 0;
        rst_n = 1'b0; cfg_valid = 1'b1; cfg_addr = 9'd3; cfg_data = 16'hFFFF;
        start = 1'b0; coef_base = '0; ntaps = '0;

        // Reset with a pending host write: nothing may leak out.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_cfg_ready", cfg_ready, 0);
        checkOutput("rst_mem_wren", mem_wren, 0);
        checkOutput("rst_mem_wrptr", mem_wrptr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_coef_valid", coef_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_mem_rden", mem_rden, 0);
        @(negedge clk);
        rst_n = 1'b1; cfg_valid = 1'b0;
        #1;
        checkOutput("release_cfg_ready", cfg_ready, 0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("rdy_en_cfg_ready", cfg_ready, 1);

        // Back-to-back writes, including a host address that truncates to 1.
        host_addr = 10'd513;
        applyStimulus(1'b1, 9'd0, 16'hAAAA, 1'b0, '0, '0);
        checkOutput("wr0_ready", cfg_ready, 1);
        applyStimulus(1'b1, 9'd1, 16'hBBBB, 1'b0, '0, '0);
        checkOutput("wr0_wren", mem_wren, 1);
        checkOutput("wr0_ptr", mem_wrptr, 0);
        checkOutput("wr0_data", mem_wrdata, 16'hAAAA);
        applyStimulus(1'b1, host_addr[8:0], 16'h1234, 1'b0, '0, '0);
        checkOutput("wr1_wren", mem_wren, 1);
        checkOutput("wr1_ptr", mem_wrptr, 1);
        checkOutput("wr1_data", mem_wrdata, 16'hBBBB);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("wr513_wren", mem_wren, 1);
        checkOutput("wr513_ptr", mem_wrptr, 1);
        checkOutput("wr513_data", mem_wrdata, 16'h1234);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("wr_idle_wren", mem_wren, 0);

        // Preload every address with i + 0x100.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), DATA_W'(i + 16'h100), 1'b0, '0, '0);
            tb_coef[i] = DATA_W'(i + 16'h100);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

        $display("[TB] basic burst");
        runBurst(9'd0, 4, 0, 1'b0, '0, '0);

        $display("[TB] wrap and clamp");
        runBurst(9'd510, 3, 0, 1'b0, '0, '0);
        checkOutput("wrap_log_size", rdptr_log.size(), 3);
        checkOutput("wrap_ptr0", rdptr_log[0], 510);
        checkOutput("wrap_ptr1", rdptr_log[1], 511);
        checkOutput("wrap_ptr2", rdptr_log[2], 0);
        runBurst(9'd0, 600, 0, 1'b0, '0, '0);
        checkOutput("clamp_beats", beats, 512);

        $display("[TB] contention");
        runBurst(9'd8, 4, 2, 1'b1, 9'd5, 16'hDEAD);
        checkOutput("post_done_cfg_ready", cfg_ready, 1);
        tb_coef[5] = 16'hDEAD;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("post_done_wren", mem_wren, 1);
        checkOutput("post_done_ptr", mem_wrptr, 5);
        checkOutput("post_done_data", mem_wrdata, 16'hDEAD);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        runBurst(9'd4, 3, 0, 1'b0, '0, '0);

        $display("[TB] zero taps");
        runBurst(9'd0, 0, 0, 1'b0, '0, '0);
        checkOutput("zero_no_reads", rdptr_log.size(), 0);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 8; i++)
            sb.push_back('{data: tb_coef[100 + i], idx: ADDR_W'(i), last: (i == 7)});
        applyStimulus(1'b0, '0, '0, 1'b1, 9'd100, 10'd8);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_coef_valid", coef_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rden", mem_rden, 0);
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
            checkOutput("abort_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
        runBurst(9'd20, 5, 0, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/filter_storage_ctrl.md
Name: filter_storage_ctrl

Overview:
Sequencer and arbiter for the 512x16 filter coefficient store (filter_storage). It shares the store between two requesters: a host configuration port that writes coefficients and the filter engine that needs a burst of N coefficients per output sample. It drives the store's write and read ports and streams read data to the engine with index and last-tap tags.

Parameters:
ADDR_W, 9, store address width; DEPTH = 2**ADDR_W.
DATA_W, 16, coefficient width.
RD_LAT, 1, store read latency in cycles (mem_rddata valid RD_LAT cycles after mem_rden).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  host write request
cfg_ready  out  1  host write accepted when cfg_valid && cfg_ready
cfg_addr  in  ADDR_W  coefficient address
cfg_data  in  DATA_W  coefficient value
start  in  1  engine burst request, single-cycle pulse
coef_base  in  ADDR_W  first address of burst, sampled on start
ntaps  in  ADDR_W+1  burst length 0..DEPTH, sampled on start
busy  out  1  burst in progress
coef_valid  out  1  coef_data/coef_idx valid
coef_data  out  DATA_W  coefficient
coef_idx  out  ADDR_W  tap index 0..N-1
coef_last  out  1  final tap of burst
done  out  1  one-cycle pulse, burst complete
start_drop  out  1  one-cycle pulse, start ignored because busy
mem_wren  out  1  to store wren
mem_wrptr  out  ADDR_W  to store wrptr
mem_wrdata  out  DATA_W  to store wrdata
mem_rden  out  1  to store rden
mem_rdptr  out  ADDR_W  to store rdptr
mem_rddata  in  DATA_W  from store rddata

Behaviour:
- Reset: all registered outputs 0; state IDLE; rdy_en flag 0, set 1 on the first clock after rst_n rises. Reset mid-burst aborts the burst; no done pulse is issued.
- cfg_ready = rdy_en && state==IDLE && !start. This is combinational; start has priority over a write in the same cycle.
- Write: a handshake at cycle t drives mem_wren=1, mem_wrptr=cfg_addr, mem_wrdata=cfg_data at t+1. Back-to-back writes are sustained at one per cycle. Addresses are ADDR_W bits, so a host address of 513 is truncated to 1 upstream.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: on start with rdy_en=1 and clamped N>0. Clamp is N = min(ntaps, DEPTH). Capture base and N.
- IDLE -> DONE: on start with N=0. No reads and no coef_valid; done asserts the next cycle.
- READ: for cycles t+1..t+N, mem_rden=1 and mem_rdptr=(base+i) mod DEPTH, i = 0..N-1. Wrap from 511 to 0 is required.
- READ -> DRAIN after issuing i=N-1. DRAIN lasts RD_LAT cycles.
- Output stream: coef_valid=1 at t+1+RD_LAT .. t+N+RD_LAT with coef_data=mem_rddata and coef_idx=i. coef_last=1 with i=N-1. A delay line of depth RD_LAT carries valid, idx and last.
- DONE: done=1 the cycle after coef_last, then the FSM returns to IDLE. busy=1 from t+1 through the done cycle inclusive.
- start while state!=IDLE is ignored, and start_drop=1 the same cycle.
- The engine has no backpressure; coefficients arrive one per cycle, continuously.
- A write and a read never reach the store in the same cycle. cfg_ready=0 for the whole burst.

Decomposition:
- Package filter_pkg holds ADDR_W, DATA_W, DEPTH, RD_LAT defaults and the state enum localparams (IDLE, READ, DRAIN, DONE).
- One sub-module, filter_rd_pipe, is the RD_LAT-deep shift line for valid/idx/last.

Test Plan:
1. Reset: hold rst_n=0 with cfg_valid=1 -> all outputs 0, cfg_ready=0. One cycle after release, cfg_ready=1.
2. Writes: addr 0 data 16'hAAAA, then addr 1 data 16'hBBBB back-to-back -> mem_wren pulses on the two following cycles with matching ptr/data. A host address of 513 arrives as 1.
3. Burst: preload addr i = i+16'h100, start base=0 ntaps=4 -> coef_valid 4 cycles from t+2, data 100..103, idx 0..3, last on idx 3, done at t+6, busy t+1..t+6.
4. Wrap/clamp: base=510 ntaps=3 -> rdptr 510,511,0. Then ntaps=600 -> exactly 512 valid beats.
5. Contention: start and cfg_valid in the same cycle -> cfg_ready=0 and no write. The write is accepted only after done. start mid-burst -> start_drop=1 and the burst is unaffected.
6. Edge: ntaps=0 -> done the next cycle, no coef_valid. rst_n low mid-burst -> coef_valid/busy drop immediately, no done, a new burst works after release.
